sa_tile_ctrl: RTL



---
 rtl/sa_pkg.sv | 21 ++
 rtl/sa_tile_ctrl_if.sv | 53 +++++
 rtl/sa_skew_gen.sv | 37 +++
 rtl/sa_tile_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array tile controller slice.
package sa_pkg;

  localparam int unsigned ARRAY_N_DEF = 16;
  localparam int unsigned VEC_W_DEF   = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } sa_ctrl_state_e;

  typedef struct packed {
    logic [VEC_W_DEF-1:0] num_vec;
    logic                 transpose;
    logic                 reuse_w;
  } sa_cfg_t;

endpackage

// File: rtl/sa_tile_ctrl_if.sv
// Tile controller bus: scheduler command, SRAM read strobes and array control.
// The perf counter signals exist only when SA_CTRL_PERF_EN is defined.
interface sa_tile_ctrl_if
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY_N = ARRAY_N_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF,
  parameter int unsigned ADDR_W  = 8
);
  logic               start;
  logic               abort;
  logic [VEC_W-1:0]   cfg_num_vec;
  logic               cfg_transpose;
  logic               cfg_reuse_w;
  logic               busy;
  logic               done;
  logic               w_rd_en;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic               act_rd_en;
  logic [ADDR_W-1:0]  act_rd_addr;
  logic [ARRAY_N-1:0] row_en;
  logic               load_w;
  logic               transpose_en;
  logic [ARRAY_N-1:0] psum_col_valid;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]        perf_busy_cycles;
  logic [15:0]        perf_tiles;

  modport master (
    output start, abort, cfg_num_vec, cfg_transpose, cfg_reuse_w,
    input  busy, done, w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    input  row_en, load_w, transpose_en, psum_col_valid,
    input  perf_busy_cycles, perf_tiles
  );
  modport slave (
    input  start, abort, cfg_num_vec, cfg_transpose, cfg_reuse_w,
    output busy, done, w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    output row_en, load_w, transpose_en, psum_col_valid,
    output perf_busy_cycles, perf_tiles
  );
`else
  modport master (
    output start, abort, cfg_num_vec, cfg_transpose, cfg_reuse_w,
    input  busy, done, w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    input  row_en, load_w, transpose_en, psum_col_valid
  );
  modport slave (
    input  start, abort, cfg_num_vec, cfg_transpose, cfg_reuse_w,
    output busy, done, w_rd_en, w_rd_addr, act_rd_en, act_rd_addr,
    output row_en, load_w, transpose_en, psum_col_valid
  );
`endif
endinterface

// File: rtl/sa_skew_gen.sv
// Single delay line turning the activation-read strobe into the per-row skew
// mask and the per-column result-valid mask via tapped delays.
module sa_skew_gen
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY_N = ARRAY_N_DEF,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               vec_valid,
  output logic [ARRAY_N-1:0] row_en,
  output logic [ARRAY_N-1:0] psum_col_valid,
  output logic               drained
);
  localparam int unsigned DLY = RD_LAT + 2 * ARRAY_N - 1;

  logic [DLY-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = {sr_q[DLY-2:0], vec_valid};
    if (clear) sr_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  // Tap k holds the strobe from k+1 cycles ago: rows after the read latency,
  // columns after a further ARRAY_N hops through the array.
  assign row_en         = sr_q[RD_LAT-1 +: ARRAY_N];
  assign psum_col_valid = sr_q[RD_LAT-1+ARRAY_N +: ARRAY_N];
  assign drained        = ~|sr_q;

endmodule

// File: rtl/sa_tile_ctrl.sv
// Weight-stationary systolic tile sequencer: weight load, skewed activation
// streaming and drain. SA_CTRL_PERF_EN adds busy-cycle and tile counters.
module sa_tile_ctrl
  import sa_pkg::*;
#(
  parameter int unsigned ARRAY_N = ARRAY_N_DEF,
  parameter int unsigned VEC_W   = VEC_W_DEF,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  sa_tile_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = VEC_W + 1;

  sa_ctrl_state_e     state_q, state_d;
  sa_cfg_t            cfg_q, cfg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               w_rd_en_q, w_rd_en_d, act_rd_en_q, act_rd_en_d;
  logic [ADDR_W-1:0]  w_rd_addr_q, w_rd_addr_d, act_rd_addr_q, act_rd_addr_d;
  logic               transpose_en_q, transpose_en_d;
  logic [RD_LAT-1:0]  wdly_q, wdly_d;
  logic [ARRAY_N-1:0] row_en, psum_col_valid;
  logic               drained, kill;

  assign kill = bus.abort && (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    cnt_d         = cnt_q;
    done_d        = 1'b0;
    w_rd_en_d     = 1'b0;
    w_rd_addr_d   = '0;
    act_rd_en_d   = 1'b0;
    act_rd_addr_d = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort && bus.cfg_num_vec != '0) begin
          cfg_d.num_vec   = bus.cfg_num_vec;
          cfg_d.transpose = bus.cfg_transpose;
          cfg_d.reuse_w   = bus.cfg_reuse_w;
          cnt_d           = '0;
          if (bus.cfg_reuse_w) begin
            state_d     = STREAM;
            act_rd_en_d = 1'b1;
          end else begin
            state_d   = LOAD_W;
            w_rd_en_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_W'(ARRAY_N - 1)) begin
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = ADDR_W'(cnt_q + CNT_W'(1));
        end
        // Stay until the read-latency tail of load_w has been issued.
        if (cnt_q == CNT_W'(ARRAY_N + RD_LAT - 1)) begin
          state_d     = STREAM;
          cnt_d       = '0;
          act_rd_en_d = 1'b1;
        end
      end
      STREAM: begin
        if (cnt_q == CNT_W'(cfg_q.num_vec) - CNT_W'(1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d         = cnt_q + CNT_W'(1);
          act_rd_en_d   = 1'b1;
          act_rd_addr_d = ADDR_W'(cnt_q + CNT_W'(1));
        end
      end
      DRAIN: begin
        if (drained) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d     = IDLE;
      cnt_d       = '0;
      done_d      = 1'b0;
      w_rd_en_d   = 1'b0;
      w_rd_addr_d = '0;
      act_rd_en_d = 1'b0;
      act_rd_addr_d = '0;
    end
    busy_d         = (state_d != IDLE);
    transpose_en_d = busy_d && cfg_d.transpose;
  end

  always_comb begin
    wdly_d[0] = w_rd_en_q;
    for (int unsigned i = 1; i < RD_LAT; i++) wdly_d[i] = wdly_q[i-1];
    if (kill) wdly_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cfg_q          <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      w_rd_en_q      <= 1'b0;
      w_rd_addr_q    <= '0;
      act_rd_en_q    <= 1'b0;
      act_rd_addr_q  <= '0;
      transpose_en_q <= 1'b0;
      wdly_q         <= '0;
    end else begin
      state_q        <= state_d;
      cfg_q          <= cfg_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      w_rd_en_q      <= w_rd_en_d;
      w_rd_addr_q    <= w_rd_addr_d;
      act_rd_en_q    <= act_rd_en_d;
      act_rd_addr_q  <= act_rd_addr_d;
      transpose_en_q <= transpose_en_d;
      wdly_q         <= wdly_d;
    end
  end

  sa_skew_gen #(
    .ARRAY_N (ARRAY_N),
    .RD_LAT  (RD_LAT)
  ) u_skew (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (kill),
    .vec_valid      (act_rd_en_q),
    .row_en         (row_en),
    .psum_col_valid (psum_col_valid),
    .drained        (drained)
  );

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.w_rd_en        = w_rd_en_q;
  assign bus.w_rd_addr      = w_rd_addr_q;
  assign bus.act_rd_en      = act_rd_en_q;
  assign bus.act_rd_addr    = act_rd_addr_q;
  assign bus.load_w         = wdly_q[RD_LAT-1];
  assign bus.transpose_en   = transpose_en_q;
  assign bus.row_en         = row_en;
  assign bus.psum_col_valid = psum_col_valid;

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_busy_q, perf_busy_d;
  logic [15:0] perf_tiles_q, perf_tiles_d;

  always_comb begin
    perf_busy_d = perf_busy_q;
    if (busy_q && perf_busy_q != '1) perf_busy_d = perf_busy_q + 32'd1;
    perf_tiles_d = perf_tiles_q + 16'(done_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_tiles_q <= '0;
    end else begin
      perf_busy_q  <= perf_busy_d;
      perf_tiles_q <= perf_tiles_d;
    end
  end

  assign bus.perf_busy_cycles = perf_busy_q;
  assign bus.perf_tiles       = perf_tiles_q;
`endif

endmodule
